mul_sequencer: RTL and testbench

Multi-cycle control stage wrapped around the CPU's combinational 32×32 signed multiplier. It latches the operands, drives them to the multiplier, waits a fixed number of settle cycles for the deep combinational path, captures the 64-bit product, then issues ordered LO and HI register writes. It sits between the ALU operand registers and the HI/LO register pair in the datapath.

---
 rtl/mul_seq_pkg.sv | 22 ++
 rtl/mul_sequencer.sv | 150 +++++++++++++++
 tb/tb_mul_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the multiply sequencer: state encoding, datapath widths
// and the 32-bit representability check on the 64-bit product.
package mul_seq_pkg;

  localparam int MUL_W  = 32;
  localparam int PROD_W = 64;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WR_LO   = 3'd3,
    ST_WR_HI   = 3'd4
  } state_e;

  // High half must be a pure sign extension of bit 31 for the product to fit.
  function automatic logic prod_ovf(input logic [PROD_W-1:0] p);
    return (p[PROD_W-1:MUL_W] != {MUL_W{p[MUL_W-1]}});
  endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Multi-cycle control around an external combinational 32x32 signed multiplier:
// latch operands, wait SETTLE_CYCLES, capture the product, then write LO then HI.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   op_a,
  input  logic [31:0]   op_b,
  output logic [31:0]   mul_m,
  output logic [31:0]   mul_q,
  input  logic [63:0]   mul_p,
  output logic [31:0]   lo_out,
  output logic [31:0]   hi_out,
  output logic          lo_we,
  output logic          hi_we,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  state_e             r_state;
  state_e             w_next;
  logic               w_accept;
  logic               w_capture;
  logic [CNT_W-1:0]   r_cnt;
  logic [MUL_W-1:0]   r_mul_m;
  logic [MUL_W-1:0]   r_mul_q;
  logic [MUL_W-1:0]   r_lo;
  logic [MUL_W-1:0]   r_hi;
  logic               r_ovf;
  logic               r_busy;
  logic               r_lo_we;
  logic               r_hi_we;
  logic               r_done;

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus accept/capture qualifiers.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_accept = 1'b1;
          w_next   = (SETTLE_LD != {CNT_W{1'b0}}) ? ST_SETTLE : ST_CAPTURE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_next = ST_CAPTURE;
        end else begin
          w_next = ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else begin
          w_capture = 1'b1;
          w_next    = ST_WR_LO;
        end
      end
      ST_WR_LO: w_next = ST_WR_HI;
      ST_WR_HI: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Settle counter: loaded on accept, counts down while settling.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= SETTLE_LD;
    end else if (r_state == ST_SETTLE && !abort && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end else if (r_state != ST_SETTLE || abort) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Operand and product registers; each holds until its next load event.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_mul_m <= 32'd0;
      r_mul_q <= 32'd0;
      r_lo    <= 32'd0;
      r_hi    <= 32'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mul_m <= op_a;
        r_mul_q <= op_b;
      end
      if (w_capture) begin
        r_lo  <= mul_p[MUL_W-1:0];
        r_hi  <= mul_p[PROD_W-1:MUL_W];
        r_ovf <= prod_ovf(mul_p);
      end
    end
  end

  // Status/strobe outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_busy  <= 1'b0;
      r_lo_we <= 1'b0;
      r_hi_we <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy  <= (w_next != ST_IDLE);
      r_lo_we <= (w_next == ST_WR_LO);
      r_hi_we <= (w_next == ST_WR_HI);
      r_done  <= (w_next == ST_WR_HI);
    end
  end

  assign mul_m  = r_mul_m;
  assign mul_q  = r_mul_q;
  assign lo_out = r_lo;
  assign hi_out = r_hi;
  assign ovf    = r_ovf;
  assign busy   = r_busy;
  assign lo_we  = r_lo_we;
  assign hi_we  = r_hi_we;
  assign done   = r_done;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with S=2 (dut) and S=0 (dut0) instances,
// each fed by a behavioural signed multiplier.
module tb_mul_sequencer;

  logic        clk;
  logic        clr_n;
  logic        start, abort;
  logic [31:0] op_a, op_b;
  logic [31:0] mul_m, mul_q, lo_out, hi_out;
  logic [63:0] mul_p;
  logic        lo_we, hi_we, busy, done, ovf;

  logic        start0, abort0;
  logic [31:0] op_a0, op_b0;
  logic [31:0] mul_m0, mul_q0, lo_out0, hi_out0;
  logic [63:0] mul_p0;
  logic        lo_we0, hi_we0, busy0, done0, ovf0;

  int vectors;
  int miscompares;

  assign mul_p  = {{32{mul_m[31]}}, mul_m} * {{32{mul_q[31]}}, mul_q};
  assign mul_p0 = {{32{mul_m0[31]}}, mul_m0} * {{32{mul_q0[31]}}, mul_q0};

  mul_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .mul_m(mul_m), .mul_q(mul_q), .mul_p(mul_p),
    .lo_out(lo_out), .hi_out(hi_out), .lo_we(lo_we), .hi_we(hi_we),
    .busy(busy), .done(done), .ovf(ovf)
  );

  mul_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .clr_n(clr_n), .start(start0), .abort(abort0),
    .op_a(op_a0), .op_b(op_b0), .mul_m(mul_m0), .mul_q(mul_q0), .mul_p(mul_p0),
    .lo_out(lo_out0), .hi_out(hi_out0), .lo_we(lo_we0), .hi_we(hi_we0),
    .busy(busy0), .done(done0), .ovf(ovf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    clr_n = 1'b0;
    #1;
    vectors++;
    if ({mul_m, mul_q, lo_out, hi_out} !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h %h, want all 0", mul_m, mul_q, lo_out, hi_out);
    end
    vectors++;
    if ({busy, lo_we, hi_we, done, ovf} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, want 00000", {busy, lo_we, hi_we, done, ovf});
    end
    vectors++;
    if ({busy0, lo_we0, hi_we0, done0, ovf0, lo_out0} !== 37'd0) begin
      miscompares++;
      $display("FAIL reset_dut0: got %b %h, want 0", {busy0, lo_we0, hi_we0, done0, ovf0}, lo_out0);
    end
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  // Full S=2 multiply; start sampled at edge n, cycle n+c sampled at the c-th negedge.
  task automatic test_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_ovf);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy, lo_we, hi_we, done} !== {c <= 5, c == 4, c == 5, c == 5}) begin
        miscompares++;
        $display("FAIL %s_flags c%0d: got %b, want %b", name, c, {busy, lo_we, hi_we, done},
                 {c <= 5, c == 4, c == 5, c == 5});
      end
      if (c == 1) begin
        vectors++;
        if ({mul_m, mul_q} !== {a, b}) begin
          miscompares++;
          $display("FAIL %s_operands: got %h %h, want %h %h", name, mul_m, mul_q, a, b);
        end
      end
      if (c == 4) begin
        vectors++;
        if (lo_out !== exp_lo) begin
          miscompares++;
          $display("FAIL %s_lo: got %h, want %h", name, lo_out, exp_lo);
        end
      end
      if (c == 5) begin
        vectors++;
        if ({hi_out, ovf} !== {exp_hi, exp_ovf}) begin
          miscompares++;
          $display("FAIL %s_hi_ovf: got %h %b, want %h %b", name, hi_out, ovf, exp_hi, exp_ovf);
        end
      end
    end
  endtask

  task automatic test_abort();
    op_a  = 32'd5;
    op_b  = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: busy got %b, want 0", busy);
    end
    for (int c = 4; c <= 7; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy, lo_we, hi_we, done, lo_out, ovf} !== {4'b0000, 32'h15, 1'b0}) begin
        miscompares++;
        $display("FAIL abort_quiet c%0d: got %b %h %b, want 0000 00000015 0", c,
                 {busy, lo_we, hi_we, done}, lo_out, ovf);
      end
    end
  endtask

  task automatic test_start_held();
    op_a  = 32'd7;
    op_b  = 32'hFFFFFFFD;
    start = 1'b1;
    @(posedge clk);
    #1 op_a = 32'd100;
    op_b = 32'd100;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      vectors++;
      if ({busy, lo_we, hi_we, done} !== {c <= 5, c == 4, c == 5, c == 5}) begin
        miscompares++;
        $display("FAIL held_flags c%0d: got %b, want %b", c, {busy, lo_we, hi_we, done},
                 {c <= 5, c == 4, c == 5, c == 5});
      end
      if (c == 5) begin
        vectors++;
        if ({mul_m, lo_out, hi_out} !== {32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF}) begin
          miscompares++;
          $display("FAIL held_result: got %h %h %h, want 00000007 ffffffeb ffffffff",
                   mul_m, lo_out, hi_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    op_a  = 32'd7;
    op_b  = 32'hFFFFFFFD;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, mul_m} !== {1'b1, 32'd7}) begin
      miscompares++;
      $display("FAIL rst_pre: got %b %h, want 1 00000007", busy, mul_m);
    end
    #2 clr_n = 1'b0;
    #1;
    vectors++;
    if ({mul_m, mul_q, lo_out, hi_out, busy, lo_we, hi_we, done, ovf} !== 133'd0) begin
      miscompares++;
      $display("FAIL rst_async: got %h %h %h %h %b, want all 0", mul_m, mul_q, lo_out, hi_out,
               {busy, lo_we, hi_we, done, ovf});
    end
    @(negedge clk);
    clr_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy, lo_we, hi_we, done} !== 4'b0000) begin
        miscompares++;
        $display("FAIL rst_quiet c%0d: got %b, want 0000", c, {busy, lo_we, hi_we, done});
      end
    end
  endtask

  task automatic test_settle0();
    op_a0  = 32'hFFFFFFFF;
    op_b0  = 32'hFFFFFFFF;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy0, lo_we0, hi_we0, done0} !== {c <= 3, c == 2, c == 3, c == 3}) begin
        miscompares++;
        $display("FAIL s0_flags c%0d: got %b, want %b", c, {busy0, lo_we0, hi_we0, done0},
                 {c <= 3, c == 2, c == 3, c == 3});
      end
      if (c == 3) begin
        vectors++;
        if ({lo_out0, hi_out0, ovf0} !== {32'd1, 32'd0, 1'b0}) begin
          miscompares++;
          $display("FAIL s0_result: got %h %h %b, want 00000001 00000000 0",
                   lo_out0, hi_out0, ovf0);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    start = 1'b0; abort = 1'b0; op_a = 32'd0; op_b = 32'd0;
    start0 = 1'b0; abort0 = 1'b0; op_a0 = 32'd0; op_b0 = 32'd0;
    test_reset();
    test_mul("neg", 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
    test_mul("ovf_pos", 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h00000000, 1'b1);
    test_mul("min_sq", 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b1);
    test_mul("prior", 32'd7, 32'd3, 32'h00000015, 32'h00000000, 1'b0);
    test_abort();
    test_start_held();
    test_reset_mid_op();
    test_settle0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
